// File: rtl/ifu_fetch_pkg.sv
// Types and constants shared by the fetch unit and its bench.
`ifndef ROOTH_DEFINES_V
`include "rooth_defines.v"
`endif

package ifu_fetch_pkg;

    localparam int unsigned CPU_W  = `CPU_WIDTH;
    localparam int unsigned FLOW_W = `FLOW_WIDTH;

    typedef enum logic [FLOW_W-1:0] {
        FLOW_WORK    = `FLOW_WORK,
        FLOW_STOP    = `FLOW_STOP,
        FLOW_REFRESH = `FLOW_REFRESH
    } flow_e;

    localparam logic [31:0] NOP_INST_DEF = `INST_NOP;

    typedef struct packed {
        logic [CPU_W-1:0] pc;
        logic [31:0]      inst;
    } fetch_entry_t;

    // Any code other than WORK or STOP (REFRESH or undefined) discards in-flight work.
    function automatic logic is_flush(input logic [FLOW_W-1:0] flow, input logic jtag_rst);
        return jtag_rst | ((flow != FLOW_WORK) && (flow != FLOW_STOP));
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Registered synchronous FIFO (no fall-through) with flush and occupancy count.
module ifu_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         data_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !flush_i && (count_q == FULL)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && !flush_i && (count_q == '0)));

endmodule

// File: rtl/rooth_defines.v
// Shared pipeline-wide constants: datapath width, flow-control codes, NOP encoding.
`ifndef ROOTH_DEFINES_V
`define ROOTH_DEFINES_V
`define CPU_WIDTH    32
`define FLOW_WIDTH   2
`define FLOW_WORK    2'd0
`define FLOW_STOP    2'd1
`define FLOW_REFRESH 2'd2
`define INST_NOP     32'h0000_0013
`endif

// File: rtl/ifu_fetch.sv
// Instruction fetch: issues word fetches for the current PC, pairs responses with
// their PC and buffers {pc, inst} for decode; stale responses are dropped on flush.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               jtag_reset_flag_i,
    input  logic [FLOW_W-1:0]  flow_if_i,
    input  logic [CPU_W-1:0]   curr_pc_i,
    output logic               fetch_stall_o,
    output logic               ibus_req_o,
    output logic [CPU_W-1:0]   ibus_addr_o,
    input  logic               ibus_gnt_i,
    input  logic               ibus_rvalid_i,
    input  logic [31:0]        ibus_rdata_i,
    output logic               inst_valid_o,
    output logic [31:0]        inst_o,
    output logic [CPU_W-1:0]   inst_pc_o,
    input  logic               inst_ready_i
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

    logic               req_pending_q, req_pending_d;
    logic               pend_stale_q, pend_stale_d;
    logic [CPU_W-1:0]   pend_pc_q, pend_pc_d;
    logic [CW-1:0]      outstanding_q, outstanding_d;
    logic [CW-1:0]      discard_q, discard_d;

    logic               flush, work, credit_ok, issue;
    logic               take_pc, drop_gnt, rsp_keep, rsp_drop, inst_pop;
    logic [CW:0]        used;
    logic [CPU_W-1:0]   push_pc;
    logic [CW-1:0]      pcq_cnt, fifo_cnt;
    logic [CPU_W-1:0]   pcq_head;
    fetch_entry_t       fifo_in, fifo_head;

    always_comb begin
        flush     = is_flush(flow_if_i, jtag_reset_flag_i);
        work      = rst_n && (flow_if_i == FLOW_WORK) && !flush;
        inst_pop  = inst_valid_o & inst_ready_i;
        used      = {1'b0, outstanding_q} + {1'b0, fifo_cnt} + {{CW{1'b0}}, req_pending_q};
        // A same-cycle pop frees a slot, which is what lets DEPTH=2 sustain one fetch per cycle.
        credit_ok = used < (DEPTH_L + {{CW{1'b0}}, inst_pop});
        issue     = work && !req_pending_q && credit_ok;

        ibus_req_o  = issue | req_pending_q;
        ibus_addr_o = '0;
        if (req_pending_q) begin
            ibus_addr_o = {pend_pc_q[CPU_W-1:2], 2'b00};
        end else if (issue) begin
            ibus_addr_o = {curr_pc_i[CPU_W-1:2], 2'b00};
        end

        take_pc  = ibus_gnt_i && (issue || (req_pending_q && !pend_stale_q && !flush));
        drop_gnt = ibus_gnt_i && req_pending_q && (pend_stale_q || flush);
        push_pc  = req_pending_q ? pend_pc_q : curr_pc_i;

        // PC may only advance once its own fetch has been granted.
        fetch_stall_o = work && !take_pc;

        rsp_drop = ibus_rvalid_i && (discard_q != '0);
        rsp_keep = ibus_rvalid_i && (discard_q == '0);

        fifo_in.pc   = pcq_head;
        fifo_in.inst = ibus_rdata_i;
    end

    always_comb begin
        req_pending_d = req_pending_q;
        pend_stale_d  = pend_stale_q;
        pend_pc_d     = pend_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (req_pending_q) begin
            if (ibus_gnt_i) begin
                req_pending_d = 1'b0;
                pend_stale_d  = 1'b0;
            end else if (flush) begin
                pend_stale_d  = 1'b1;
            end
        end else if (issue && !ibus_gnt_i) begin
            req_pending_d = 1'b1;
            pend_stale_d  = 1'b0;
            pend_pc_d     = curr_pc_i;
        end

        if (flush) begin
            outstanding_d = '0;
            discard_d     = discard_q + outstanding_q + CW'(drop_gnt) - CW'(ibus_rvalid_i);
        end else begin
            outstanding_d = outstanding_q + CW'(take_pc) - CW'(rsp_keep);
            discard_d     = discard_q + CW'(drop_gnt) - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pending_q <= 1'b0;
            pend_stale_q  <= 1'b0;
            pend_pc_q     <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            req_pending_q <= req_pending_d;
            pend_stale_q  <= pend_stale_d;
            pend_pc_q     <= pend_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ifu_fifo #(
        .WIDTH (CPU_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (take_pc && !flush),
        .data_i  (push_pc),
        .pop_i   (rsp_keep && !flush),
        .flush_i (flush),
        .count_o (pcq_cnt),
        .data_o  (pcq_head)
    );

    ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rsp_keep && !flush),
        .data_i  (fifo_in),
        .pop_i   (inst_pop),
        .flush_i (flush),
        .count_o (fifo_cnt),
        .data_o  (fifo_head)
    );

    assign inst_valid_o = (fifo_cnt != '0);
    assign inst_o       = inst_valid_o ? fifo_head.inst : NOP_INST;
    assign inst_pc_o    = inst_valid_o ? fifo_head.pc : '0;

    a_pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        pcq_cnt == outstanding_q);

endmodule
